mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; only 32 is supported.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports i_req in 1 fetch request; i_addr in ADDR_W fetch address; i_ready out 1 fetch accepted; i_rvalid out 1 fetch data valid; i_rdata out DATA_W fetch data.
REQ-006 SHALL have ports d_req in 1 data request; d_we in 1 store=1/load=0; d_size in 2 (00 byte, 01 half, 10 word, 11 illegal); d_addr in ADDR_W; d_wdata in DATA_W (right-justified).
REQ-007 SHALL have ports d_ready out 1 data accepted; d_rvalid out 1 completion; d_rdata out DATA_W load data; d_err out 1 misalign/illegal flag.
REQ-008 SHALL have ports m_req out 1; m_we out 1; m_addr out ADDR_W (bits[1:0]=0); m_be out 4; m_wdata out DATA_W; m_ready in 1 request taken; m_rvalid in 1 response (read data or write ack); m_rdata in DATA_W.
REQ-009 SHALL have port stall out 1; high while any request is pending or outstanding.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, ERR.
REQ-011 In IDLE, with d_req=1, SHALL assert d_ready combinationally, latch d_* and go to ISSUE (or ERR if misaligned); data has fixed priority over fetch.
REQ-012 In IDLE, with i_req=1 and d_req=0, SHALL assert i_ready, latch i_addr, record owner=fetch and go to ISSUE.
REQ-013 x_ready SHALL be 0 in every state other than IDLE; requesters hold x_req and payload until x_ready.
REQ-014 In ISSUE, m_req/m_we/m_addr/m_be/m_wdata SHALL come from registers, stay stable until m_ready=1, then go to WAIT.
REQ-015 In WAIT, on m_rvalid=1, SHALL register the response, pulse owner's x_rvalid for exactly one cycle on the next cycle, and return to IDLE.
REQ-016 Minimum latency: accept at cycle 0, m_req at cycle 1 (m_ready=1), m_rvalid at cycle 2, x_rvalid at cycle 3; next accept no earlier than cycle 3.
REQ-017 Fetch SHALL use m_we=0 and m_be=1111.
REQ-018 m_be SHALL be 0001<<a (byte), 0011<<a (half), 1111 (word), where a=d_addr[1:0].
REQ-019 m_wdata SHALL be {4{wdata[7:0]}} (byte), {2{wdata[15:0]}} (half), or wdata (word).
REQ-020 d_rdata SHALL equal m_rdata >> (8*a), zero-filled; sign/zero extension stays in the datapath.
REQ-021 Misalignment SHALL be half with a[0]=1, word with a!=0, or d_size=11; the request is accepted, never sent to memory, goes to ERR, then pulses d_rvalid and d_err together next cycle with d_rdata=0.
REQ-022 d_err SHALL be 0 on every aligned completion.
REQ-023 m_rvalid outside WAIT SHALL be ignored; m_ready outside ISSUE SHALL be ignored.
REQ-024 stall SHALL equal (state!=IDLE) | (i_req & ~i_ready) | (d_req & ~d_ready).
REQ-025 Simultaneous i_req and d_req in IDLE: data SHALL be served first; fetch SHALL be accepted at the next IDLE.

Reset
REQ-026 reset=0 at a clock edge SHALL force IDLE and clear all output registers: m_req=0, m_we=0, m_addr=0, m_be=0, m_wdata=0, i_rvalid=0, d_rvalid=0, d_err=0, i_rdata=0, d_rdata=0.
REQ-027 Reset mid-transaction SHALL drop the transaction silently; any later m_rvalid SHALL be ignored.

Structure
REQ-028 Shared package mem_arb_pkg SHALL hold the state enum, d_size encodings (SZ_B, SZ_H, SZ_W) and BE constants.
REQ-029 Lane logic (m_be, m_wdata replication, d_rdata shift, misalign detect) SHALL be a combinational sub-module lane_align.

Verification
REQ-030 Fetch: i_req, i_addr=0x100, m_ready=1 at once, m_rdata=0x00500093 one cycle later -> i_rvalid at cycle 3, i_rdata=0x00500093, m_be=1111.
REQ-031 Store byte: d_addr=0x203, d_size=00, d_wdata=0xAB -> m_addr=0x200, m_be=1000, m_wdata=0xABABABAB, m_we=1, d_rvalid on ack.
REQ-032 Load half: d_addr=0x402, m_rdata=0xBEEF1234 -> m_be=1100, d_rdata=0x0000BEEF.
REQ-033 Collision: i_req and d_req in the same cycle -> d_ready first, i_ready at the IDLE after d_rvalid, stall high throughout.
REQ-034 Misaligned word at 0x301 -> no m_req, d_rvalid=d_err=1 two cycles after accept.
REQ-035 reset=0 in WAIT, then m_rvalid=1 -> no x_rvalid, FSM in IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   - arb_state_t : arbiter FSM states
//   - SZ_*        : d_size encodings (byte / half / word; 2'b11 is illegal)
//   - BE_*        : base byte-enable patterns before shifting into lane position
//   - WORD_W      : the only supported data width
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ERR   = 2'd3
  } arb_state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam int WORD_W = 32;

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane steering for the data port.
// Ports:
//   size, addr_lo  : access size and byte offset of the incoming data request
//   wdata          : right-justified store data
//   be             : byte enables placed on the addressed lanes
//   wdata_rep      : store data replicated across all lanes
//   misalign       : access cannot be issued (misaligned or illegal size)
//   rd_off, rdata  : byte offset of the outstanding load and the raw memory word
//   rdata_shift    : memory word shifted down so the addressed byte is in [7:0]
module lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] wdata,
  input  logic [1:0]        rd_off,
  input  logic [WORD_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [WORD_W-1:0] wdata_rep,
  output logic [WORD_W-1:0] rdata_shift,
  output logic              misalign
);

  always_comb begin
    be       = BE_NONE;
    misalign = 1'b0;
    case (size)
      SZ_B: be = BE_BYTE << addr_lo;
      SZ_H: begin
        be       = BE_HALF << addr_lo;
        misalign = addr_lo[0];
      end
      SZ_W: begin
        be       = BE_WORD;
        misalign = (addr_lo != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

  // Every lane carries the source byte that belongs there after replication,
  // so memory picks the right one regardless of which enable is set.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_rep[8*gi +: 8] = (size == SZ_B) ? wdata[7:0] :
                                    (size == SZ_H) ? wdata[8*(gi%2) +: 8] :
                                                     wdata[8*gi +: 8];
    end
  endgenerate

  // Zero-filled; sign/zero extension is left to the consumer.
  assign rdata_shift = rdata >> {rd_off, 3'b000};

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store data port onto one
// single-outstanding memory port. Data has fixed priority over fetch.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   i_req/i_addr        : fetch request; i_ready accept, i_rvalid/i_rdata response
//   d_req/d_we/d_size/
//   d_addr/d_wdata      : data request; d_ready accept, d_rvalid/d_rdata/d_err completion
//   m_req/m_we/m_addr/
//   m_be/m_wdata        : registered memory request, held until m_ready
//   m_rvalid/m_rdata    : memory response (read data or write ack)
//   stall               : any request pending or transaction outstanding
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_be,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  arb_state_t        state_reg, state_next;
  logic              owner_fetch_reg;
  logic [1:0]        off_reg;

  logic [3:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;
  logic              lane_mis;

  lane_align u_lane_align (
    .size        (d_size),
    .addr_lo     (d_addr[1:0]),
    .wdata       (d_wdata),
    .rd_off      (off_reg),
    .rdata       (m_rdata),
    .be          (lane_be),
    .wdata_rep   (lane_wdata),
    .rdata_shift (lane_rdata),
    .misalign    (lane_mis)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    d_ready    = 1'b0;
    i_ready    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (d_req) begin
          d_ready    = 1'b1;
          state_next = lane_mis ? ERR : ISSUE;
        end else if (i_req) begin
          i_ready    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   if (m_ready)  state_next = WAIT;
      WAIT:    if (m_rvalid) state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_fetch_reg <= 1'b0;
      off_reg         <= 2'b00;
      m_req           <= 1'b0;
      m_we            <= 1'b0;
      m_addr          <= '0;
      m_be            <= BE_NONE;
      m_wdata         <= '0;
      i_rvalid        <= 1'b0;
      i_rdata         <= '0;
      d_rvalid        <= 1'b0;
      d_rdata         <= '0;
      d_err           <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses.
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (d_ready) begin
            owner_fetch_reg <= 1'b0;
            off_reg         <= d_addr[1:0];
            // A misaligned access is absorbed locally and never reaches memory.
            if (!lane_mis) begin
              m_req   <= 1'b1;
              m_we    <= d_we;
              m_addr  <= d_addr & ALIGN_MASK;
              m_be    <= lane_be;
              m_wdata <= lane_wdata;
            end
          end else if (i_ready) begin
            owner_fetch_reg <= 1'b1;
            off_reg         <= 2'b00;
            m_req           <= 1'b1;
            m_we            <= 1'b0;
            m_addr          <= i_addr & ALIGN_MASK;
            m_be            <= BE_WORD;
            m_wdata         <= '0;
          end
        end
        ISSUE: if (m_ready) m_req <= 1'b0;
        WAIT: begin
          if (m_rvalid) begin
            if (owner_fetch_reg) begin
              i_rvalid <= 1'b1;
              i_rdata  <= m_rdata;
            end else begin
              d_rvalid <= 1'b1;
              d_rdata  <= lane_rdata;
            end
          end
        end
        ERR: begin
          d_rvalid <= 1'b1;
          d_err    <= 1'b1;
          d_rdata  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign stall = (state_reg != IDLE) | (i_req & ~i_ready) | (d_req & ~d_ready);

endmodule
